// File: rtl/spi_minion_adapter_pkg.sv
// Shared field positions and packet layout for the SPI minion adapter.
package spi_adapter_pkg;

    localparam int NBITS_DEFAULT = 32;

    // Push packet flags
    function automatic int val_wr_bit(input int nbits);
        return nbits + 1;
    endfunction

    function automatic int val_rd_bit(input int nbits);
        return nbits;
    endfunction

    // Pull packet flags
    function automatic int val_bit(input int nbits);
        return nbits + 1;
    endfunction

    function automatic int spc_bit(input int nbits);
        return nbits;
    endfunction

    typedef struct packed {
        logic                     flag_hi;
        logic                     flag_lo;
        logic [NBITS_DEFAULT-1:0] data;
    } spi_pkt_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_minion_adapter_if.sv
// SPI minion packet ports plus the downstream request/response streams.
interface spi_minion_adapter_if #(parameter int nbits = 32);
    logic             push_en;
    logic [nbits+1:0] push_msg;
    logic             pull_en;
    logic [nbits+1:0] pull_msg;
    logic             send_val;
    logic             send_rdy;
    logic [nbits-1:0] send_msg;
    logic             recv_val;
    logic             recv_rdy;
    logic [nbits-1:0] recv_msg;

    modport master (
        output push_en, push_msg, pull_en, send_rdy, recv_val, recv_msg,
        input  pull_msg, send_val, send_msg, recv_rdy
    );

    modport slave (
        input  push_en, push_msg, pull_en, send_rdy, recv_val, recv_msg,
        output pull_msg, send_val, send_msg, recv_rdy
    );
endinterface

// File: rtl/spi_minion_adapter_fifo.sv
// Circular-buffer FIFO; full/empty reflect the count at the start of the cycle.
module spi_minion_adapter_fifo #(
    parameter int nbits = 32,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [nbits-1:0] enq_data,
    input  logic             deq,
    output logic             full,
    output logic             empty,
    output logic [nbits-1:0] head
);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    logic [nbits-1:0] mem_q [depth];
    logic [nbits-1:0] mem_d [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_enq, do_deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CW'(depth));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_enq   = enq & ~full;
        do_deq   = deq & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_enq) begin
            mem_d[wr_ptr_q] = enq_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_enq, do_deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/spi_minion_adapter.sv
// SPI minion push/pull packets to val/rdy streams, with request and response FIFOs.
// Optional SPI_MINION_ADAPTER_DROP_CNT_EN adds a saturating dropped-write counter.
module spi_minion_adapter
    import spi_adapter_pkg::*;
#(
    parameter int nbits = 32,
    parameter int depth = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_minion_adapter_if.slave  bus
`ifdef SPI_MINION_ADAPTER_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);
    localparam int VAL_WR = val_wr_bit(nbits);
    localparam int VAL_RD = val_rd_bit(nbits);

    logic             reqq_full, reqq_empty, rspq_full, rspq_empty;
    logic [nbits-1:0] reqq_head, rspq_head;
    logic             wr_req, reqq_enq, reqq_deq, rspq_enq, rspq_deq;
    logic             armed_now;
    logic             rd_armed_q, rd_armed_d;

    // A pull in the same cycle re-arms before the push consumes the flag.
    always_comb begin
        wr_req     = bus.push_en & bus.push_msg[VAL_WR];
        reqq_enq   = wr_req & ~reqq_full;
        reqq_deq   = ~reqq_empty & bus.send_rdy;
        rspq_enq   = bus.recv_val & ~rspq_full;
        armed_now  = bus.pull_en ? ~rspq_empty : rd_armed_q;
        rspq_deq   = bus.push_en & bus.push_msg[VAL_RD] & armed_now;
        rd_armed_d = bus.push_en ? 1'b0 : armed_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_armed_q <= 1'b0;
        end else begin
            rd_armed_q <= rd_armed_d;
        end
    end

    spi_minion_adapter_fifo #(.nbits(nbits), .depth(depth)) u_reqq (
        .clk      (clk),
        .reset    (reset),
        .enq      (reqq_enq),
        .enq_data (bus.push_msg[nbits-1:0]),
        .deq      (reqq_deq),
        .full     (reqq_full),
        .empty    (reqq_empty),
        .head     (reqq_head)
    );

    spi_minion_adapter_fifo #(.nbits(nbits), .depth(depth)) u_rspq (
        .clk      (clk),
        .reset    (reset),
        .enq      (rspq_enq),
        .enq_data (bus.recv_msg),
        .deq      (rspq_deq),
        .full     (rspq_full),
        .empty    (rspq_empty),
        .head     (rspq_head)
    );

    assign bus.send_val = ~reqq_empty;
    assign bus.send_msg = reqq_head;
    assign bus.recv_rdy = ~rspq_full;
    assign bus.pull_msg = {~rspq_empty, ~reqq_full,
                           rspq_empty ? {nbits{1'b0}} : rspq_head};

`ifdef SPI_MINION_ADAPTER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (wr_req & reqq_full) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_spi_minion_adapter.sv
// Scoreboard bench: queue-based reference model, monitor compares at each negedge.
module tb_spi_minion_adapter;
    import spi_adapter_pkg::*;

    localparam int NB    = 32;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_minion_adapter_if #(.nbits(NB)) bus ();

`ifdef SPI_MINION_ADAPTER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    spi_minion_adapter #(.nbits(NB), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef SPI_MINION_ADAPTER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [NB-1:0] m_req[$];
    logic [NB-1:0] m_rsp[$];
    logic [NB-1:0] exp_send[$];
    logic [NB-1:0] exp_rd[$];
    logic [NB-1:0] ds_q[$];
    bit            m_armed = 1'b0;
    int            m_drop  = 0;

    bit echo_en = 1'b0, rand_rdy = 1'b0, mon_en = 1'b0, end_req = 1'b0, end_done = 1'b0;

    logic [NB-1:0] cap_data;
    bit            cap_valid = 1'b0;
    logic [NB+1:0] exp_pull;
    bit            md_req_full, md_rsp_full, md_armed;
    logic [NB-1:0] md_tmp;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: DUT outputs against the model state from the previous edge.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_pull = {m_rsp.size() != 0, m_req.size() < DEPTH,
                        (m_rsp.size() != 0) ? m_rsp[0] : {NB{1'b0}}};
            check("send_val", 64'(bus.send_val), 64'(m_req.size() != 0));
            check("recv_rdy", 64'(bus.recv_rdy), 64'(m_rsp.size() < DEPTH));
            check("pull_msg", 64'(bus.pull_msg), 64'(exp_pull));
`ifdef SPI_MINION_ADAPTER_DROP_CNT_EN
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
            if (bus.send_val && bus.send_rdy) begin
                if (exp_send.size() == 0) check("send_unexpected", 64'(1), 64'(0));
                else check("send_msg", 64'(bus.send_msg), 64'(exp_send.pop_front()));
            end
            if (reset) cap_valid = 1'b0;
            if (bus.pull_en) begin
                cap_valid = bus.pull_msg[NB+1];
                cap_data  = bus.pull_msg[NB-1:0];
            end
            if (bus.push_en) begin
                if (bus.push_msg[NB] && cap_valid) begin
                    if (exp_rd.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
                    else check("rd_data", 64'(cap_data), 64'(exp_rd.pop_front()));
                end
                cap_valid = 1'b0;
            end
            if (end_req && !end_done) begin
                check("rd_drained", 64'(exp_rd.size()), 64'(0));
                check("send_drained", 64'(exp_send.size()), 64'(0));
                end_done = 1'b1;
            end
        end
    end

    // Reference model: advance queues using the inputs seen at the coming edge.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            m_req.delete();
            m_rsp.delete();
            exp_send.delete();
            ds_q.delete();
            m_armed = 1'b0;
            m_drop  = 0;
        end else begin
            md_req_full = (m_req.size() == DEPTH);
            md_rsp_full = (m_rsp.size() == DEPTH);
            md_armed    = bus.pull_en ? (m_rsp.size() != 0) : m_armed;
            if (bus.recv_val && !md_rsp_full) begin
                m_rsp.push_back(bus.recv_msg);
                if (echo_en && ds_q.size() != 0) void'(ds_q.pop_front());
            end
            if (m_req.size() != 0 && bus.send_rdy) begin
                md_tmp = m_req.pop_front();
                if (echo_en) ds_q.push_back(md_tmp);
            end
            if (bus.push_en && bus.push_msg[NB+1]) begin
                if (!md_req_full) begin
                    m_req.push_back(bus.push_msg[NB-1:0]);
                    exp_send.push_back(bus.push_msg[NB-1:0]);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if (bus.push_en && bus.push_msg[NB] && md_armed) void'(m_rsp.pop_front());
            m_armed = bus.push_en ? 1'b0 : md_armed;
        end
    end

    task automatic tick();
        if (rand_rdy) bus.send_rdy = 1'($urandom_range(0, 1));
        if (echo_en) begin
            if (ds_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                bus.recv_val = 1'b1;
                bus.recv_msg = ds_q[0];
            end else begin
                bus.recv_val = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [NB-1:0] d);
        bus.push_en  = 1'b1;
        bus.push_msg = {2'b10, d};
        tick();
        bus.push_en  = 1'b0;
        bus.push_msg = '0;
    endtask

    task automatic pull(output bit v);
        bus.pull_en = 1'b1;
        v = bus.pull_msg[NB+1];
        tick();
        bus.pull_en = 1'b0;
    endtask

    task automatic ack(input bit rd);
        bus.push_en  = 1'b1;
        bus.push_msg = {1'b0, rd, {NB{1'b0}}};
        tick();
        bus.push_en  = 1'b0;
        bus.push_msg = '0;
    endtask

    task automatic recv1(input logic [NB-1:0] d);
        bus.recv_val = 1'b1;
        bus.recv_msg = d;
        tick();
        bus.recv_val = 1'b0;
    endtask

    logic [NB-1:0] vals[$];
    bit v;
    int wr_i, rd_n, budget;

    initial begin
        bus.push_en = 0; bus.push_msg = '0; bus.pull_en = 0;
        bus.send_rdy = 0; bus.recv_val = 0; bus.recv_msg = '0;
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Write path
        wr(32'hA5);
        tick();
        bus.send_rdy = 1'b1;
        tick();
        bus.send_rdy = 1'b0;
        tick();

        // Overflow: third write dropped, stream yields 1,2
        wr(32'd1); wr(32'd2); wr(32'd3);
        tick();
        bus.send_rdy = 1'b1;
        repeat (3) tick();
        bus.send_rdy = 1'b0;

        // Read path with acknowledge
        recv1(32'h5A);
        exp_rd.push_back(32'h5A);
        pull(v); ack(1'b1);
        pull(v); ack(1'b0);

        // Unacknowledged read keeps the head
        recv1(32'h3C);
        pull(v); ack(1'b0);
        exp_rd.push_back(32'h3C);
        pull(v); ack(1'b1);

        // Response FIFO full: third offer is refused
        recv1(32'h31); recv1(32'h32); recv1(32'h33);
        exp_rd.push_back(32'h31);
        bus.pull_en = 1'b1;
        bus.push_en = 1'b1;
        bus.push_msg = {2'b01, {NB{1'b0}}};
        tick();
        bus.pull_en = 1'b0; bus.push_en = 1'b0; bus.push_msg = '0;
        exp_rd.push_back(32'h32);
        pull(v); ack(1'b1);

        // Reset mid-run with both FIFOs occupied
        wr(32'hAA); wr(32'hBB);
        recv1(32'hCC);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        wr(32'hDD);
        bus.send_rdy = 1'b1;
        tick(); tick();
        bus.send_rdy = 1'b0;

        // Loopback with random send_rdy and echo timing
        vals = '{32'd7, 32'd8, 32'd9};
        for (int i = 0; i < 9; i++) vals.push_back($urandom);
        foreach (vals[i]) exp_rd.push_back(vals[i]);
        echo_en = 1'b1;
        rand_rdy = 1'b1;
        wr_i = 0; rd_n = 0; budget = 0;
        while ((wr_i < vals.size() || rd_n < vals.size()) && budget < 3000) begin
            budget++;
            if (wr_i < vals.size() && bus.pull_msg[NB] && $urandom_range(0, 1) == 1) begin
                wr(vals[wr_i]);
                wr_i++;
            end else begin
                pull(v);
                v = v && ($urandom_range(0, 3) != 0);
                ack(v);
                if (v) rd_n++;
            end
        end
        echo_en = 1'b0;
        rand_rdy = 1'b0;
        bus.send_rdy = 1'b0;
        bus.recv_val = 1'b0;
        repeat (3) tick();

        end_req = 1'b1;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
